// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbitration slice.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned MAX_N  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // First set bit of valid scanning ptr, ptr+1, ... modulo n (n <= MAX_N).
  function automatic logic [2:0] rr_pick(input logic [MAX_N-1:0] valid,
                                         input logic [2:0]       ptr,
                                         input int unsigned      n);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !found && valid[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [IW-1:0]  grant_id;
  logic           busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done;
  logic           timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, grant_id, busy, tx_start, tx_data, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, grant_id, busy, tx_start, tx_data, timeout_err
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid at or after ptr, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int unsigned IW = $clog2(N);

  logic [MAX_N-1:0] valid_ext;
  logic [2:0]       win;

  always_comb begin
    valid_ext         = '0;
    valid_ext[N-1:0]  = valid_i;
    win               = rr_pick(valid_ext, 3'(ptr_i), N);
    idx_o             = IW'(win);
    any_o             = |valid_i;
    onehot_o          = '0;
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(HOLD_TIMEOUT) + 1;

  state_e              state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       grant_q;
  logic [DATA_W-1:0]   data_q;
  logic                last_q;
  logic                busy_q;
  logic                tx_start_q;
  logic                terr_q;
  logic [CW-1:0]       hold_cnt_q;

  logic [N-1:0]        pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [N-1:0]        req_ready_d;
  logic [IW-1:0]       sel_idx;
  logic [DATA_W-1:0]   sel_byte;
  logic                sel_last;

  uart_rr_pick #(.N(N)) u_pick (
    .valid_i  (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (32'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  // req_ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    req_ready_d = '0;
    sel_idx     = (state_q == ST_HOLD) ? grant_q : pick_idx;
    sel_byte    = bus.req_data[32'(sel_idx)*DATA_W +: DATA_W];
    sel_last    = bus.req_last[sel_idx];
    if (!reset) begin
      case (state_q)
        ST_IDLE: req_ready_d = pick_oh;
        ST_HOLD: if (bus.req_valid[grant_q]) req_ready_d[grant_q] = 1'b1;
        default: req_ready_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      terr_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      tx_start_q <= 1'b0;
      terr_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            data_q     <= sel_byte;
            last_q     <= sel_last;
            grant_q    <= pick_idx;
            busy_q     <= 1'b1;
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (bus.tx_done) begin
            if (last_q) begin
              rr_ptr_q <= next_idx(grant_q);
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              hold_cnt_q <= '0;
              state_q    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.req_valid[grant_q]) begin
            data_q     <= sel_byte;
            last_q     <= sel_last;
            tx_start_q <= 1'b1;
            state_q    <= ST_START;
          end else if (hold_cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
            terr_q   <= 1'b1;
            rr_ptr_q <= next_idx(grant_q);
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (hold_cnt_q != '1) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_d;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = data_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N=4, HOLD_TIMEOUT=8).
module tb_uart_tx_arbiter;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  uart_tx_arbiter_if #(.N(4)) bus ();

  uart_tx_arbiter #(.N(4), .HOLD_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] b, input logic last);
    bus.req_data[8*i +: 8] = b;
    bus.req_last[i]        = last;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start got %0b exp 0", bus.tx_start); end
    tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
    tests++; if (bus.grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant got %0d exp 0", bus.grant_id); end
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
    tests++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL reset_terr got %0b exp 0", bus.timeout_err); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_byte(2, 8'h5A, 1'b1);
    bus.req_valid = 4'b0100;
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got %b exp 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
    tests++; if (bus.tx_start !== 1'b1) begin fails++; $display("FAIL single_start got %0b exp 1", bus.tx_start); end
    tests++; if (bus.tx_data !== 8'h5A) begin fails++; $display("FAIL single_data got %h exp 5a", bus.tx_data); end
    tests++; if (bus.grant_id !== 2'd2) begin fails++; $display("FAIL single_grant got %0d exp 2", bus.grant_id); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy got %0b exp 1", bus.busy); end
    tick();
    tests++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse got %0b exp 0", bus.tx_start); end
    tests++; if (bus.tx_data !== 8'h5A) begin fails++; $display("FAIL single_data_hold got %h exp 5a", bus.tx_data); end
    pulse_done();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got %0b exp 0", bus.busy); end
    // rr_ptr should now be 3, so 3 wins over 0.
    bus.req_valid = 4'b1001;
    #1;
    tests++; if (bus.req_ready !== 4'b1000) begin fails++; $display("FAIL single_rrptr got %b exp 1000", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL withdrawn_busy got %0b exp 0", bus.busy); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_oh;
    do_reset();
    for (int i = 0; i < 4; i++) set_byte(i, 8'hA0 + 8'(i), 1'b1);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      #1;
      tests++; if (bus.req_ready !== exp_oh) begin fails++; $display("FAIL fair_ready[%0d] got %b exp %b", k, bus.req_ready, exp_oh); end
      tick();
      tests++; if (bus.grant_id !== 2'(k % 4)) begin fails++; $display("FAIL fair_grant[%0d] got %0d exp %0d", k, bus.grant_id, k % 4); end
      tests++; if (bus.tx_data !== 8'hA0 + 8'(k % 4)) begin fails++; $display("FAIL fair_data[%0d] got %h exp %h", k, bus.tx_data, 8'hA0 + 8'(k % 4)); end
      tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL fair_ready_start[%0d] got %b exp 0000", k, bus.req_ready); end
      tick();
      tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL fair_ready_wait[%0d] got %b exp 0000", k, bus.req_ready); end
      pulse_done();
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_frame_lock();
    do_reset();
    set_byte(1, 8'h11, 1'b0);
    set_byte(2, 8'h44, 1'b1);
    bus.req_valid = 4'b0110;
    #1;
    tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL lock_ready0 got %b exp 0010", bus.req_ready); end
    tick();
    tests++; if (bus.tx_data !== 8'h11) begin fails++; $display("FAIL lock_byte0 got %h exp 11", bus.tx_data); end
    tick();
    pulse_done();
    // Owner stalls for two cycles; requester 2 must stay ignored.
    bus.req_valid = 4'b0100;
    #1;
    tests++; if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL lock_stall_ready got %b exp 0000", bus.req_ready); end
    tick();
    tick();
    tests++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin fails++; $display("FAIL lock_stall_owner got busy=%0b grant=%0d exp busy=1 grant=1", bus.busy, bus.grant_id); end
    set_byte(1, 8'h22, 1'b0);
    bus.req_valid = 4'b0110;
    #1;
    tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL lock_ready1 got %b exp 0010", bus.req_ready); end
    tick();
    tests++; if (bus.tx_data !== 8'h22) begin fails++; $display("FAIL lock_byte1 got %h exp 22", bus.tx_data); end
    tick();
    pulse_done();
    set_byte(1, 8'h33, 1'b1);
    #1;
    tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL lock_ready2 got %b exp 0010", bus.req_ready); end
    tick();
    tests++; if (bus.tx_data !== 8'h33) begin fails++; $display("FAIL lock_byte2 got %h exp 33", bus.tx_data); end
    bus.req_valid = 4'b0100;
    tick();
    pulse_done();
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL lock_next_ready got %b exp 0100", bus.req_ready); end
    tick();
    tests++; if (bus.tx_data !== 8'h44 || bus.grant_id !== 2'd2) begin fails++; $display("FAIL lock_next got data=%h grant=%0d exp data=44 grant=2", bus.tx_data, bus.grant_id); end
    bus.req_valid = 4'b0000;
    tick();
    pulse_done();
  endtask

  task automatic test_hold_timeout();
    int early;
    do_reset();
    set_byte(0, 8'h30, 1'b0);
    set_byte(1, 8'h77, 1'b1);
    bus.req_valid = 4'b0011;
    #1;
    tests++; if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL to_ready got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0010;
    tick();
    pulse_done();
    early = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (bus.timeout_err !== 1'b0 || bus.req_ready !== 4'b0000) early++;
    end
    tests++; if (early != 0) begin fails++; $display("FAIL to_early got %0d bad cycles exp 0", early); end
    tick();
    tests++; if (bus.timeout_err !== 1'b1) begin fails++; $display("FAIL to_pulse got %0b exp 1", bus.timeout_err); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL to_busy got %0b exp 0", bus.busy); end
    tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL to_next_ready got %b exp 0010", bus.req_ready); end
    tick();
    tests++; if (bus.timeout_err !== 1'b0) begin fails++; $display("FAIL to_pulse_len got %0b exp 0", bus.timeout_err); end
    tests++; if (bus.grant_id !== 2'd1 || bus.tx_data !== 8'h77) begin fails++; $display("FAIL to_next got grant=%0d data=%h exp grant=1 data=77", bus.grant_id, bus.tx_data); end
    bus.req_valid = 4'b0000;
    tick();
    pulse_done();
  endtask

  task automatic test_spurious_async();
    do_reset();
    pulse_done();
    tests++; if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin fails++; $display("FAIL spurious_done got busy=%0b start=%0b exp 0 0", bus.busy, bus.tx_start); end
    set_byte(2, 8'hC2, 1'b1);
    set_byte(3, 8'hC3, 1'b1);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    pulse_done();
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tests++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd3) begin fails++; $display("FAIL async_pre got busy=%0b grant=%0d exp 1 3", bus.busy, bus.grant_id); end
    bus.req_valid = 4'b1100;
    #2;
    reset = 1'b1;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL async_busy got %0b exp 0", bus.busy); end
    tests++; if (bus.tx_data !== 8'h00 || bus.grant_id !== 2'd0) begin fails++; $display("FAIL async_regs got data=%h grant=%0d exp 00 0", bus.tx_data, bus.grant_id); end
    tests++; if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0 || bus.timeout_err !== 1'b0) begin fails++; $display("FAIL async_strobes got ready=%b start=%0b terr=%0b exp 0000 0 0", bus.req_ready, bus.tx_start, bus.timeout_err); end
    tick();
    reset = 1'b0;
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL async_first_grant got %b exp 0100", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_fairness();
    test_frame_lock();
    test_hold_timeout();
    test_spurious_async();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
